// File: rtl/seller_pkg.sv
// rtl/seller_pkg.sv - shared types and constants for the vending transaction controller
package seller_pkg;

  localparam int CREDIT_W = 4;
  localparam int COIN_W   = 3;

  localparam logic [COIN_W-1:0] COIN_D1 = 3'd1;
  localparam logic [COIN_W-1:0] COIN_D2 = 3'd2;
  localparam logic [COIN_W-1:0] COIN_D3 = 3'd4;

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_e;
  typedef enum logic {PROD_A, PROD_B} prod_e;

endpackage

// File: rtl/seller_coin_decode.sv
// rtl/seller_coin_decode.sv - priority coin decode (d1 > d2 > d3) with credit saturation check
module seller_coin_decode
  import seller_pkg::*;
#(
  parameter int MAX_CREDIT = 15
) (
  input  logic                d1_i,
  input  logic                d2_i,
  input  logic                d3_i,
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [COIN_W-1:0]   value_o,
  output logic                present_o,
  output logic                fits_o
);

  localparam logic [CREDIT_W:0] MAX_C = MAX_CREDIT[CREDIT_W:0];

  logic [CREDIT_W:0] sum;

  always_comb begin
    value_o = '0;
    if (d1_i)      value_o = COIN_D1;
    else if (d2_i) value_o = COIN_D2;
    else if (d3_i) value_o = COIN_D3;
  end

  assign present_o = d1_i | d2_i | d3_i;
  // One extra bit so an overflowing sum is caught instead of wrapping.
  assign sum       = {1'b0, credit_i} + {2'b00, value_o};
  assign fits_o    = present_o && (sum <= MAX_C);

endmodule

// File: rtl/seller_ctrl.sv
// rtl/seller_ctrl.sv - vending transaction controller: credit, select/cancel arbitration, vend, change.
// Optional SELLER_TIMEOUT_EN: COLLECT inactivity timeout acting as an internal cancel.
module seller_ctrl
  import seller_pkg::*;
#(
  parameter int PRICE_A    = 3,
  parameter int PRICE_B    = 5,
  parameter int MAX_CREDIT = 15,
  parameter int TIMEOUT    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                d1,
  input  logic                d2,
  input  logic                d3,
  input  logic                sel_a,
  input  logic                sel_b,
  input  logic                cancel,
  output logic                drink_a,
  output logic                drink_b,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  localparam logic [CREDIT_W-1:0] PRICE_A_C = PRICE_A[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] PRICE_B_C = PRICE_B[CREDIT_W-1:0];

  state_e              state_q, state_d;
  prod_e               prod_q, prod_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                drink_a_q, drink_a_d, drink_b_q, drink_b_d;
  logic                change_q, change_d, reject_q, reject_d, busy_q, busy_d;

  logic [COIN_W-1:0]   coin_val;
  logic                coin_present, coin_fits;
  logic                sel_any, sel_ok, timeout_hit, do_cancel;
  logic [CREDIT_W-1:0] sel_price, vend_price;

  seller_coin_decode #(.MAX_CREDIT(MAX_CREDIT)) u_coin (
    .d1_i      (d1),
    .d2_i      (d2),
    .d3_i      (d3),
    .credit_i  (credit_q),
    .value_o   (coin_val),
    .present_o (coin_present),
    .fits_o    (coin_fits)
  );

  // sel_a wins arbitration outright; its price alone decides acceptance.
  assign sel_any    = sel_a | sel_b;
  assign sel_price  = sel_a ? PRICE_A_C : PRICE_B_C;
  assign sel_ok     = sel_any && (credit_q >= sel_price);
  assign vend_price = (prod_q == PROD_A) ? PRICE_A_C : PRICE_B_C;
  assign do_cancel  = (cancel || timeout_hit) && (credit_q != '0);

`ifdef SELLER_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             collect_idle;

  assign collect_idle = (state_q == COLLECT) && !sel_any && !coin_fits;
  assign timeout_hit  = collect_idle && (tmr_q == TMR_W'(TIMEOUT - 1));
  assign tmr_d        = (collect_idle && !timeout_hit && !cancel) ? tmr_q + 1'b1 : '0;

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  logic unused_timeout;
  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    prod_d   = prod_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (do_cancel) begin
          state_d  = CHANGE;
          reject_d = coin_present;
        end else if (sel_ok) begin
          state_d  = VEND;
          prod_d   = sel_a ? PROD_A : PROD_B;
          reject_d = coin_present;
        end else if (coin_present) begin
          if (coin_fits) begin
            credit_d = credit_q + {1'b0, coin_val};
            state_d  = COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      VEND: begin
        credit_d = credit_q - vend_price;
        state_d  = (credit_d != '0) ? CHANGE : IDLE;
        reject_d = coin_present;
      end
      CHANGE: begin
        credit_d = credit_q - 1'b1;
        state_d  = (credit_d == '0) ? IDLE : CHANGE;
        reject_d = coin_present;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered, so they are decoded from the next state.
    drink_a_d = (state_d == VEND) && (prod_d == PROD_A);
    drink_b_d = (state_d == VEND) && (prod_d == PROD_B);
    change_d  = (state_d == CHANGE);
    busy_d    = (state_d == VEND) || (state_d == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prod_q    <= PROD_A;
      credit_q  <= '0;
      drink_a_q <= 1'b0;
      drink_b_q <= 1'b0;
      change_q  <= 1'b0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      credit_q  <= credit_d;
      drink_a_q <= drink_a_d;
      drink_b_q <= drink_b_d;
      change_q  <= change_d;
      reject_q  <= reject_d;
      busy_q    <= busy_d;
    end
  end

  assign drink_a      = drink_a_q;
  assign drink_b      = drink_b_q;
  assign change_pulse = change_q;
  assign coin_reject  = reject_q;
  assign busy         = busy_q;
  assign credit       = credit_q;

endmodule

// File: doc/seller_ctrl.md
Name: seller_ctrl

Overview:
Transaction controller for the vending datapath. It accumulates coin credit, arbitrates between two product selections and a cancel request, issues one drink-dispense pulse, then sequences change out one unit per cycle. It sits between the coin/keypad front end and the drink and change hoppers.

Parameters:
PRICE_A, 3, price of product A in coin units (1..MAX_CREDIT)
PRICE_B, 5, price of product B in coin units (1..MAX_CREDIT)
MAX_CREDIT, 15, maximum credit held; width of credit is 4 bits
TIMEOUT, 16, idle cycles in COLLECT before automatic refund (only with the optional feature)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
d1  input  1  coin worth 1 unit, one-cycle pulse
d2  input  1  coin worth 2 units, one-cycle pulse
d3  input  1  coin worth 4 units, one-cycle pulse
sel_a  input  1  select product A, pulse
sel_b  input  1  select product B, pulse
cancel  input  1  abort and refund, pulse
drink_a  output  1  dispense product A, one-cycle pulse
drink_b  output  1  dispense product B, one-cycle pulse
change_pulse  output  1  release one unit of change per high cycle
coin_reject  output  1  a presented coin was not credited, one-cycle pulse
busy  output  1  high in VEND and CHANGE
credit  output  4  current credit register

Behaviour:
- Single clock domain. Synchronous active-high reset on clk, named rst. All outputs are registered.
- Reset values: state=IDLE; credit=0; all pulses=0; busy=0. Reset mid-VEND or mid-CHANGE discards the remaining credit and issues no further pulses.
- States: IDLE (credit=0), COLLECT (credit>0), VEND, CHANGE.
- Coin decode: d1 has priority over d2, and d2 over d3. Only one coin is credited per cycle. Other coins asserted in the same cycle are ignored with no reject.
- IDLE/COLLECT, priority per cycle is cancel > selection > coin:
  - cancel with credit>0: go to CHANGE. With credit=0 it is ignored.
  - sel_a has priority over sel_b. An accepted select (credit >= price) goes to VEND and records the product. A coin in the same cycle is rejected.
  - A select with insufficient credit is ignored. A coin in the same cycle is then processed normally.
  - Coin: if credit+value <= MAX_CREDIT, credit += value (5-bit compare, no wrap) and state=COLLECT. Otherwise credit is unchanged and coin_reject is high the next cycle.
- VEND (exactly 1 cycle): the recorded drink_x is high for this cycle and credit -= price. Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE: change_pulse is high each cycle and credit decrements by 1 at the end of each cycle. On the cycle credit reaches 0, the next state is IDLE. N units of change give N consecutive pulses.
- In VEND/CHANGE, any coin gives coin_reject high the next cycle. select and cancel are ignored.
- Latency: a triggering input sampled at edge k makes the corresponding output high in cycle k+1.
- drink_a, drink_b and change_pulse are never high in the same cycle.

Optional Feature:
SELLER_TIMEOUT_EN
- Defined: a counter in COLLECT clears on any accepted coin or attempted select. When it reaches TIMEOUT cycles, the block behaves as an internal cancel and goes to CHANGE. The counter is held at 0 outside COLLECT.
- Undefined: no counter, and credit is held indefinitely. The TIMEOUT parameter is unused.

Decomposition:
- Package seller_pkg: state enum (IDLE, COLLECT, VEND, CHANGE), coin value constants (1, 2, 4), and the credit width constant (4).
- One sub-module is natural: seller_coin_decode. It holds the priority coin decode plus the saturation check and outputs the coin value and accept/reject.

Test Plan:
- d2, d2 then sel_a -> credit 2, 4; drink_a one cycle; credit becomes 1; one change_pulse; back to IDLE.
- d3, d1 then sel_b -> credit 5; drink_b one cycle; no change_pulse; IDLE.
- d1 then sel_b (insufficient) together with d2 -> credit 1 then 3; no drink; state COLLECT.
- Credit 14, then d2 -> coin_reject one cycle; credit stays 14. Then cancel -> 14 consecutive change_pulses.
- During CHANGE, d3 -> coin_reject; credit unaffected. Same-cycle cancel and sel_a with credit 6 -> refund 6; no drink.
- rst asserted mid-CHANGE -> next cycle: credit 0, IDLE, no pulses. With SELLER_TIMEOUT_EN: d1 then 16 idle cycles -> one change_pulse.
